// File: rtl/muldiv_pkg.sv
// Purpose: shared encodings for the multiply arbiter (FSM states, pipe grant, counter sizing).
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        PIPE1 = 1'b0,
        PIPE2 = 1'b1
    } pipe_t;

    // Step counter must be able to hold WIDTH.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Purpose: latched-operand unsigned shift-add multiplier datapath, one partial product per step.
// Latency: product complete WIDTH steps after start.
// Backpressure: none; the controller decides when to start and step.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   acc
);

    // a_sh holds A<<count and b_sh[0] holds B[count]; shifting both each step
    // gives the same partial products as indexing by count, without a barrel shifter.
    logic [2*WIDTH-1:0] a_sh;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_sh;

    // Latch operands at start, then accumulate one partial product per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc_q <= '0;
        end else if (start) begin
            a_sh  <= {{WIDTH{1'b0}}, a_in};
            b_sh  <= b_in;
            acc_q <= '0;
        end else if (step) begin
            if (b_sh[0]) begin
                acc_q <= acc_q + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_arbiter.sv
// Purpose: shares one iterative multiplier between pipe-1 and pipe-2 execute; arbitrates, sequences, stalls.
// Latency: fixed, grant in cycle 0, Done/Result in cycle WIDTH+1, back to IDLE the cycle after.
// Backpressure: requesting pipe stalled until its Done; loser stalled through the foreign op. MULDIV_RR_EN selects round-robin ties.
module muldiv_arbiter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Req1,
    input  logic                 Req2,
    input  logic [WIDTH-1:0]     SrcA1,
    input  logic [WIDTH-1:0]     SrcB1,
    input  logic [WIDTH-1:0]     SrcA2,
    input  logic [WIDTH-1:0]     SrcB2,
    input  logic                 FlushE,
    output logic                 StallE1,
    output logic                 StallE2,
    output logic                 Done1,
    output logic                 Done2,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 Busy
);

    localparam int            CW        = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    pipe_t              grant;
    pipe_t              winner;
    pipe_t              tie_pick;
    logic [CW-1:0]      count;
    logic               start;
    logic               step;
    logic               done_vld;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] acc;

`ifdef MULDIV_RR_EN
    pipe_t rr_ptr;

    // Preferred pipe flips after every completed operation; flushed ops do not count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= PIPE1;
        end else if (done_vld) begin
            rr_ptr <= (rr_ptr == PIPE1) ? PIPE2 : PIPE1;
        end
    end

    assign tie_pick = rr_ptr;
`else
    assign tie_pick = PIPE1;
`endif

    // Pick the winner: a lone requester always wins, ties go to tie_pick.
    always_comb begin
        winner = PIPE2;
        if (Req1 && Req2) begin
            winner = tie_pick;
        end else if (Req1) begin
            winner = PIPE1;
        end
    end

    assign op_a = (winner == PIPE1) ? SrcA1 : SrcA2;
    assign op_b = (winner == PIPE1) ? SrcB1 : SrcB2;

    // Next-state and datapath control; flush aborts RUN/DONE and blocks a grant in IDLE.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if ((Req1 || Req2) && !FlushE) begin
                    start     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (FlushE) begin
                    state_nxt = IDLE;
                end else begin
                    step = 1'b1;
                    if (count == LAST_STEP) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant and step counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= PIPE1;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                grant <= winner;
                count <= '0;
            end else if (step) begin
                count <= count + CW'(1);
            end
        end
    end

    seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst_n (reset),
        .start (start),
        .step  (step),
        .a_in  (op_a),
        .b_in  (op_b),
        .acc   (acc)
    );

    // A flush landing in the DONE cycle swallows the pulse.
    assign done_vld = (state == DONE) && !FlushE;
    assign Done1    = done_vld && (grant == PIPE1);
    assign Done2    = done_vld && (grant == PIPE2);
    assign Result   = done_vld ? acc : '0;
    assign Busy     = (state != IDLE);

    // Stalls are combinational from the request, so reset must gate them to read 0 at once.
    assign StallE1  = reset && Req1 && !Done1;
    assign StallE2  = reset && Req2 && !Done2;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Purpose: randomized self-checking bench for muldiv_arbiter against a transaction-level model.
// Latency: model expects grant at op cycle 0, Done at WIDTH+1, next grant at WIDTH+2.
// Backpressure: model expects StallEx = Reqx & ~Donex while requests are held.
module tb_muldiv_arbiter;

    localparam int WIDTH  = 32;
    localparam int PW     = 2 * WIDTH;
    localparam int OP_CYC = WIDTH + 2;

    logic             clk;
    logic             reset;
    logic             Req1;
    logic             Req2;
    logic [WIDTH-1:0] SrcA1;
    logic [WIDTH-1:0] SrcB1;
    logic [WIDTH-1:0] SrcA2;
    logic [WIDTH-1:0] SrcB2;
    logic             FlushE;
    logic             StallE1;
    logic             StallE2;
    logic             Done1;
    logic             Done2;
    logic [PW-1:0]    Result;
    logic             Busy;
    logic [4:0]       ctl_obs;

    int checks   = 0;
    int failures = 0;
`ifdef MULDIV_RR_EN
    int ptr_m    = 1;
`endif

    muldiv_arbiter #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .Req1    (Req1),
        .Req2    (Req2),
        .SrcA1   (SrcA1),
        .SrcB1   (SrcB1),
        .SrcA2   (SrcA2),
        .SrcB2   (SrcB2),
        .FlushE  (FlushE),
        .StallE1 (StallE1),
        .StallE2 (StallE2),
        .Done1   (Done1),
        .Done2   (Done2),
        .Result  (Result),
        .Busy    (Busy)
    );

    assign ctl_obs = {StallE1, StallE2, Done1, Done2, Busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int tie_winner();
`ifdef MULDIV_RR_EN
        return ptr_m;
`else
        return 1;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] rnd_operand();
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 0) return '0;
        if (sel == 1) return '1;
        return WIDTH'($urandom);
    endfunction

    // Hold the given requests for up to n_ops back-to-back operations; with release_on_done
    // the winning pipe retires its multiply after Done and drops its request.
    task automatic run_ops(input bit r1_in, input bit r2_in, input int n_ops, input bit release_on_done,
                           input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                           input logic [WIDTH-1:0] a2, input logic [WIDTH-1:0] b2);
        bit            r1;
        bit            r2;
        bit            dn;
        int            ph;
        int            w;
        logic [PW-1:0] prod;
        logic [4:0]    exp_ctl;
        r1 = r1_in;
        r2 = r2_in;
        w = 1;
        prod = '0;
        Req1 = r1; Req2 = r2; FlushE = 1'b0;
        SrcA1 = a1; SrcB1 = b1; SrcA2 = a2; SrcB2 = b2;
        for (int c = 0; c < n_ops * OP_CYC; c++) begin
            ph = c % OP_CYC;
            if (ph == 0) begin
                if (!r1 && !r2) break;
                if (r1 && r2) w = tie_winner();
                else w = r1 ? 1 : 2;
                prod = (w == 1) ? PW'(a1) * PW'(b1) : PW'(a2) * PW'(b2);
            end
            dn = (ph == WIDTH + 1);
            exp_ctl = {r1 && !(dn && w == 1), r2 && !(dn && w == 2),
                       dn && w == 1, dn && w == 2, ph != 0};
            @(negedge clk);
            check_eq($sformatf("ctl_c%0d", c), 64'(ctl_obs), 64'(exp_ctl));
            if (dn) check_eq($sformatf("result_c%0d", c), Result, prod);
            @(posedge clk);
            #1;
            if (dn) begin
`ifdef MULDIV_RR_EN
                ptr_m = 3 - ptr_m;
`endif
                if (release_on_done) begin
                    if (w == 1) r1 = 1'b0;
                    else r2 = 1'b0;
                end
            end
            if (c + 1 == n_ops * OP_CYC) begin
                r1 = 1'b0;
                r2 = 1'b0;
            end
            Req1 = r1;
            Req2 = r2;
            // Operands only matter on grant cycles; scramble them everywhere else.
            if ((c + 1) % OP_CYC == 0) begin
                SrcA1 = a1; SrcB1 = b1; SrcA2 = a2; SrcB2 = b2;
            end else begin
                SrcA1 = $urandom; SrcB1 = $urandom; SrcA2 = $urandom; SrcB2 = $urandom;
            end
        end
        @(negedge clk);
        check_eq("idle_ctl", 64'(ctl_obs), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Flush in IDLE blocks the grant; flush mid-RUN aborts with no Done.
    task automatic run_flush();
        logic [4:0] exp_ctl;
        Req1 = 1'b0; Req2 = 1'b1; FlushE = 1'b1;
        SrcA2 = $urandom; SrcB2 = $urandom;
        @(negedge clk);
        check_eq("flush_idle_ctl", 64'(ctl_obs), 64'(5'b01000));
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            exp_ctl = {1'b0, Req2, 1'b0, 1'b0, (c >= 1 && c <= 10)};
            @(negedge clk);
            check_eq($sformatf("flush_ctl_c%0d", c), 64'(ctl_obs), 64'(exp_ctl));
            @(posedge clk);
            #1;
            if (c + 1 == 10) FlushE = 1'b1;
            if (c + 1 == 11) begin
                FlushE = 1'b0;
                Req2 = 1'b0;
            end
        end
    endtask

    // Reset in cycle 15 of a pipe-1 op, then a fresh op from IDLE.
    task automatic run_reset_mid();
        Req1 = 1'b1; Req2 = 1'b0; FlushE = 1'b0;
        SrcA1 = $urandom; SrcB1 = $urandom;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check_eq("rstmid_ctl", 64'(ctl_obs), 64'(0));
        check_eq("rstmid_result", Result, 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
`ifdef MULDIV_RR_EN
        ptr_m = 1;
`endif
        run_ops(1'b1, 1'b0, 1, 1'b1, rnd_operand(), rnd_operand(), rnd_operand(), rnd_operand());
    endtask

    initial begin
        int sel;
        reset = 1'b0; Req1 = 1'b1; Req2 = 1'b1; FlushE = 1'b0;
        SrcA1 = $urandom; SrcB1 = $urandom; SrcA2 = $urandom; SrcB2 = $urandom;
        #3;
        check_eq("reset_ctl", 64'(ctl_obs), 64'(0));
        check_eq("reset_result", Result, 64'(0));
        repeat (2) @(posedge clk);
        #1;
        Req1 = 1'b0; Req2 = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;

        run_ops(1'b1, 1'b0, 1, 1'b1, 32'd3, 32'd5, 32'd0, 32'd0);
        run_ops(1'b1, 1'b1, 2, 1'b1, 32'd7, 32'd6, 32'd9, 32'd4);
        run_ops(1'b0, 1'b1, 1, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_ops(1'b1, 1'b0, 1, 1'b1, 32'd0, WIDTH'($urandom), 32'd0, 32'd0);
        run_ops(1'b1, 1'b1, 3, 1'b0, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        run_flush();
        run_ops(1'b1, 1'b1, 3, 1'b0, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));

        for (int i = 0; i < 6; i++) begin
            sel = $urandom_range(1, 3);
            run_ops(sel != 2, sel != 1, $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                    rnd_operand(), rnd_operand(), rnd_operand(), rnd_operand());
        end

        run_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
